// File: rtl/fetch_mem_responder.sv
// fetch_mem_responder: AXI4 INCR burst slave memory behind the fetch M00_AXI port.
// Optional macro FETCH_MEM_SLVERR_EN: range-check beats and wlast, answer SLVERR.
module fetch_mem_responder #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH          = 256
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                      s00_axi_awlen,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wlast,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int MW = $clog2(MEM_DEPTH);
`ifdef FETCH_MEM_SLVERR_EN
  localparam logic [IW:0] DEPTH_X = (IW + 1)'(MEM_DEPTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_t;

  state_t state_q, state_d;

  logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rlast_q, rlast_d;

  logic [DW-1:0] mem [MEM_DEPTH];

  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_word;
  logic [1:0]    rd_resp;
  logic          wr_ok;
  logic          mem_we;

  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;

  assign s00_axi_awready = s00_axi_aresetn && (state_q == S_IDLE);
  assign s00_axi_arready = s00_axi_aresetn && (state_q == S_IDLE)
                           && !s00_axi_awvalid;
  assign s00_axi_wready  = s00_axi_aresetn && (state_q == S_WDATA);
  assign s00_axi_bvalid  = s00_axi_aresetn && (state_q == S_WRESP);
  assign s00_axi_rvalid  = s00_axi_aresetn && (state_q == S_RDATA);

  assign s00_axi_bid   = id_q;
  assign s00_axi_bresp = {err_q, 1'b0};
  assign s00_axi_rid   = id_q;
  assign s00_axi_rdata = rdata_q;
  assign s00_axi_rresp = rresp_q;
  assign s00_axi_rlast = rlast_q;

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign b_hs  = s00_axi_bvalid && s00_axi_bready;
  assign r_hs  = s00_axi_rvalid && s00_axi_rready;

`ifndef FETCH_MEM_SLVERR_EN
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wlast};
`else
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`endif

  // Word to fetch next: the AR address when idle, else the following word.
  always_comb begin
    rd_idx = idx_q + IW'(1);
    if (state_q == S_IDLE) begin
      rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
  end

  // Combinational memory read plus range check for read and write beats.
  always_comb begin
    rd_word = mem[rd_idx[MW-1:0]];
    rd_resp = 2'b00;
    wr_ok   = 1'b1;
`ifdef FETCH_MEM_SLVERR_EN
    if ({1'b0, rd_idx} >= DEPTH_X) begin
      rd_word = '0;
      rd_resp = 2'b10;
    end
    wr_ok = ({1'b0, idx_q} < DEPTH_X);
`endif
  end

  // Next-state and datapath updates for the burst FSM.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = s00_axi_awid;
          idx_d   = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          len_d   = s00_axi_awlen;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end else if (ar_hs) begin
          id_d    = s00_axi_arid;
          idx_d   = rd_idx;
          len_d   = s00_axi_arlen;
          cnt_d   = '0;
          rdata_d = rd_word;
          rresp_d = rd_resp;
          rlast_d = (s00_axi_arlen == 8'd0);
          state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          mem_we = wr_ok;
          idx_d  = idx_q + IW'(1);
          cnt_d  = cnt_q + 8'd1;
`ifdef FETCH_MEM_SLVERR_EN
          if (!wr_ok || (s00_axi_wlast != (cnt_q == len_q))) begin
            err_d = 1'b1;
          end
`endif
          if (cnt_q == len_q) begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          state_d = S_IDLE;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = rd_idx;
            cnt_d   = cnt_q + 8'd1;
            rdata_d = rd_word;
            rresp_d = rd_resp;
            rlast_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end

  // Byte-strobed memory write; contents are not reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s00_axi_wstrb[b]) begin
          mem[idx_q[MW-1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb_fetch_mem_responder: scoreboard bench for fetch_mem_responder.
// Reference memory model predicts B/R responses; a monitor checks them.
module tb_fetch_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [0:0]  awid, arid, bid, rid;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic        rlast, rvalid, rready;

  fetch_mem_responder dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awid    (awid),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awlen   (awlen),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wlast   (wlast),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bid     (bid),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_arid    (arid),
    .s00_axi_araddr  (araddr),
    .s00_axi_arlen   (arlen),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rid     (rid),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rlast   (rlast),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [0:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t exp_r[$];
  b_exp_t exp_b[$];

  logic [31:0] mdl [256];
  logic [31:0] wd  [256];
  logic [3:0]  ws  [256];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, handshake never came", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bounded wait expired");
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [11:0] addr, input int k);
    return (int'(addr[11:2]) + k) % 1024;
  endfunction

  task automatic do_write(input logic [0:0] id, input logic [11:0] addr,
                          input int len, input int lastb, input bit gaps);
    b_exp_t e;
    int w, n;
    bit err;
    err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      w = widx(addr, k);
`ifdef FETCH_MEM_SLVERR_EN
      if ((k == lastb) != (k == len)) err = 1'b1;
      if (w >= 256) begin
        err = 1'b1;
        continue;
      end
`endif
      w = w % 256;
      for (int b = 0; b < 4; b++) begin
        if (ws[k][b]) mdl[w][8*b +: 8] = wd[k][8*b +: 8];
      end
    end
    e.id   = id;
    e.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(e);

    awid    = id;
    awaddr  = addr;
    awlen   = 8'(len);
    awvalid = 1'b1;
    n = 0;
    while (!awready) begin
      tick();
      n++;
      if (n > 200) timeout("aw_wait");
    end
    tick();
    awvalid = 1'b0;
    chk("w_ready_first", {31'b0, wready}, 32'd1);
    for (int k = 0; k <= len; k++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      wvalid = 1'b1;
      wdata  = wd[k];
      wstrb  = ws[k];
      wlast  = (k == lastb);
      n = 0;
      while (!wready) begin
        tick();
        n++;
        if (n > 200) timeout("w_wait");
      end
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("b_latency", {31'b0, bvalid}, 32'd1);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1;
    n = 0;
    while (!bvalid) begin
      tick();
      n++;
      if (n > 200) timeout("b_wait");
    end
    tick();
    bready = 1'b0;
    chk("idle_after_b", {31'b0, awready}, 32'd1);
  endtask

  task automatic do_read(input logic [0:0] id, input logic [11:0] addr,
                         input int len, input int mode, input int abort_at);
    r_exp_t e;
    int w, n, got, cyc;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k <= len; k++) begin
      w = widx(addr, k);
      e.id   = id;
      e.last = (k == len);
`ifdef FETCH_MEM_SLVERR_EN
      if (w >= 256) begin
        e.data = 32'h0;
        e.resp = 2'b10;
      end else begin
        e.data = mdl[w];
        e.resp = 2'b00;
      end
`else
      e.data = mdl[w % 256];
      e.resp = 2'b00;
`endif
      exp_r.push_back(e);
    end

    arid    = id;
    araddr  = addr;
    arlen   = 8'(len);
    arvalid = 1'b1;
    n = 0;
    while (!arready) begin
      tick();
      n++;
      if (n > 200) timeout("ar_wait");
    end
    tick();
    arvalid = 1'b0;
    chk("r_first", {31'b0, rvalid}, 32'd1);
    got = 0;
    cyc = 0;
    while (got <= len) begin
      if (got == abort_at) begin
        rready  = 1'b0;
        aresetn = 1'b0;
        tick();
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        aresetn = 1'b1;
        exp_r.delete();
        #1;
        chk("rst_idle", {31'b0, awready}, 32'd1);
        return;
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = pat[cyc % 4];
      endcase
      if (rvalid && rready) got++;
      tick();
      cyc++;
      if (cyc > 3000) timeout("r_burst");
    end
    rready = 1'b0;
    chk("r_idle_after", {31'b0, rvalid}, 32'd0);
    if (mode == 0) chk("r_cycles", cyc, len + 1);
  endtask

  b_exp_t      mb;
  r_exp_t      mr;
  bit          h_on = 1'b0;
  logic [31:0] h_data;
  logic [1:0]  h_resp;
  logic        h_last;

  // Monitor: pops the scoreboard on every B/R handshake, checks R stability.
  always @(negedge clk) begin
    if (!aresetn) begin
      h_on = 1'b0;
    end else begin
      if (h_on && rvalid) begin
        chk("r_hold_data", rdata, h_data);
        chk("r_hold_resp", {30'b0, rresp}, {30'b0, h_resp});
        chk("r_hold_last", {31'b0, rlast}, {31'b0, h_last});
      end
      h_on   = rvalid && !rready;
      h_data = rdata;
      h_resp = rresp;
      h_last = rlast;
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_extra: got bresp %b want none", bresp);
        end else begin
          mb = exp_b.pop_front();
          chk("bid", {31'b0, bid}, {31'b0, mb.id});
          chk("bresp", {30'b0, bresp}, {30'b0, mb.resp});
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          total++;
          bad++;
          $display("FAIL r_extra: got rdata %h want none", rdata);
        end else begin
          mr = exp_r.pop_front();
          chk("rid", {31'b0, rid}, {31'b0, mr.id});
          chk("rdata", rdata, mr.data);
          chk("rresp", {30'b0, rresp}, {30'b0, mr.resp});
          chk("rlast", {31'b0, rlast}, {31'b0, mr.last});
        end
      end
    end
  end

  initial begin
    int len, a;
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready0", {31'b0, awready}, 32'd0);
    chk("rst_arready0", {31'b0, arready}, 32'd0);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid0", {31'b0, rvalid}, 32'd0);
    chk("rst_rlast", {31'b0, rlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_ids", {30'b0, bid, rid}, 32'd0);
    aresetn = 1'b1;
    #1;
    chk("idle_awready", {31'b0, awready}, 32'd1);
    chk("idle_arready", {31'b0, arready}, 32'd1);

    for (int k = 0; k < 256; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
    end
    do_write(1'b0, 12'h000, 255, 255, 1'b0);

    for (int k = 0; k < 8; k++) begin
      wd[k] = 32'(k + 1);
      ws[k] = 4'hF;
    end
    do_write(1'b1, 12'h000, 7, 7, 1'b0);
    do_read(1'b1, 12'h000, 7, 0, -1);

    wd[0] = 32'hAABBCCDD;
    ws[0] = 4'hF;
    do_write(1'b0, 12'h040, 0, 0, 1'b0);
    wd[0] = 32'h11223344;
    ws[0] = 4'b0011;
    do_write(1'b0, 12'h040, 0, 0, 1'b0);
    do_read(1'b0, 12'h040, 0, 0, -1);

    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
    end
    arid    = 1'b1;
    araddr  = 12'h080;
    arlen   = 8'd3;
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    chk("both_awready", {31'b0, awready}, 32'd1);
    chk("both_arready", {31'b0, arready}, 32'd0);
    do_write(1'b0, 12'h080, 3, 3, 1'b0);
    do_read(1'b1, 12'h080, 3, 0, -1);

    do_read(1'b0, 12'h000, 3, 2, -1);

    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
    end
    do_write(1'b1, 12'h3F8, 3, 3, 1'b0);
    do_read(1'b1, 12'h3F8, 3, 0, -1);
    do_read(1'b0, 12'h000, 1, 0, -1);

`ifdef FETCH_MEM_SLVERR_EN
    do_read(1'b1, 12'h400, 0, 0, -1);
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
    end
    do_write(1'b0, 12'h100, 3, 2, 1'b0);
    do_read(1'b0, 12'h100, 3, 0, -1);
`endif

    do_read(1'b1, 12'h020, 7, 0, 3);
    do_read(1'b0, 12'h020, 7, 0, -1);

    for (int t = 0; t < 40; t++) begin
      a   = int'($urandom_range(0, 1023)) * 4;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= len; k++) begin
          wd[k] = $urandom;
          ws[k] = 4'($urandom_range(0, 15));
        end
        do_write(1'($urandom_range(0, 1)), 12'(a), len, len, 1'b1);
      end else begin
        do_read(1'($urandom_range(0, 1)), 12'(a), len, 1, -1);
      end
    end

    repeat (3) tick();
    chk("b_queue_empty", exp_b.size(), 32'd0);
    chk("r_queue_empty", exp_r.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
